mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory port between the I-cache miss path and the D-cache (loads/stores raised by the
//  control unit's READ/WRITE). Sequences each transfer, stalls the losing requester via its BUSYWAIT, and
//  round-robins on contention. Sits between the two caches and the memory model; watchdog flags hung transfers.
// PARAMETERS
//  ADDR_W          28    block address width
//  DATA_W          128   block data width
//  TIMEOUT_CYCLES  1023  max WAIT-state cycles before abort; 0 disables the watchdog
// PORTS
//  CLK          in   1        clock, rising edge
//  RESET        in   1        asynchronous, active-low reset
//  IREAD        in   1        I-cache block read request (level, held until its IBUSYWAIT=0)
//  IADDR        in   ADDR_W   I-cache block address
//  IBUSYWAIT    out  1        stall to I-cache
//  IREADDATA    out  DATA_W   read block to I-cache
//  DREAD        in   1        D-cache block read request
//  DWRITE       in   1        D-cache block write request
//  DADDR        in   ADDR_W   D-cache block address
//  DWRITEDATA   in   DATA_W   D-cache write block
//  DBUSYWAIT    out  1        stall to D-cache
//  DREADDATA    out  DATA_W   read block to D-cache
//  MREAD        out  1        memory read strobe
//  MWRITE       out  1        memory write strobe
//  MADDR        out  ADDR_W   memory address
//  MWRITEDATA   out  DATA_W   memory write data
//  MREADDATA    in   DATA_W   memory read data, valid when MBUSYWAIT falls
//  MBUSYWAIT    in   1        memory busy
//  TIMEOUT_ERR  out  1        sticky watchdog flag
// BEHAVIOUR
//  - Reset (async, RESET=0): state IDLE, MREAD=MWRITE=0, MADDR=0, MWRITEDATA=0, read-data reg=0, LAST=I,
//    timeout counter=0, TIMEOUT_ERR=0. Reset mid-transfer drops strobes immediately; no completion reported.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//    IDLE : arbitrate on IREAD, DREAD|DWRITE. None -> stay. One -> grant it. Both -> grant requester != LAST.
//           On grant register GNT, MADDR, MWRITEDATA, op (DWRITE beats DREAD if both high); go ISSUE.
//    ISSUE: strobe asserted; MBUSYWAIT ignored this cycle; go WAIT.
//    WAIT : strobe held; MBUSYWAIT=0 at edge -> capture MREADDATA (reads only), go DONE;
//           counter reaches TIMEOUT_CYCLES -> set TIMEOUT_ERR, go DONE (data reg unchanged).
//    DONE : strobes low; granted requester's BUSYWAIT=0 this cycle; LAST<=GNT; go IDLE.
//  - MREAD/MWRITE are registered and high only in ISSUE/WAIT; never both high.
//  - BUSYWAIT (combinational): xBUSYWAIT = x_request & ~(state==DONE & GNT==x). Requester sees 1 from the cycle
//    it raises the request; sees 0 for exactly one cycle (DONE) per served transfer.
//  - Request must drop or change in DONE; IDLE re-samples next cycle, so back-to-back requests are legal.
//  - IREADDATA = DREADDATA = read-data reg; valid only in the owner's DONE cycle.
//  - Min transfer latency: request-to-DONE = 3 cycles with MBUSYWAIT already low on WAIT's first edge.
//  - Requests deasserted mid-transfer are ignored; the transfer completes, DONE is still spent.
//  - Timeout counter clears on entry to ISSUE, counts in WAIT, saturates. TIMEOUT_ERR cleared only by reset.
// STRUCTURE
//  - Shared package rv32_mem_pkg: FSM state localparams (IDLE/ISSUE/WAIT/DONE), grant encoding (GNT_I=0,
//    GNT_D=1), op encoding (OP_RD, OP_WR).
//  - One sub-module: rr_pick2 (2-way round-robin pick from req[1:0] and LAST, combinational).
//  - Top holds FSM, address/data/op registers, read-data register, watchdog counter.
// TESTING
//  1 Reset: RESET=0 mid-WAIT with MREAD=1 -> MREAD=0, state IDLE, TIMEOUT_ERR=0 same cycle.
//  2 Lone I read: IREAD=1, IADDR=0x0000010, mem busy 5 cycles, MREADDATA=0xA5..A5 -> MREAD 6 cycles,
//    IBUSYWAIT low one cycle with IREADDATA=0xA5..A5; DBUSYWAIT stays 0.
//  3 Contention after reset: IREAD=DREAD=1 same cycle -> D served first (LAST=I), I next; then both
//    re-requested -> D served next (LAST=I again).
//  4 DREAD=DWRITE=1, DADDR=0x0000020, DWRITEDATA=0x1234 -> MWRITE=1, MREAD=0, MWRITEDATA=0x1234.
//  5 Watchdog: TIMEOUT_CYCLES=8, MBUSYWAIT stuck 1 -> DONE after 8 WAIT cycles, TIMEOUT_ERR=1 sticky,
//    next request still served normally.
//  6 Back-to-back: DWRITE held across DONE with new DADDR -> second transfer starts ISSUE 2 cycles later.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the main-memory port arbiter: FSM states, grant and op codes.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. req[0] is the I-cache, req[1] the D-cache.
// On contention the requester that was NOT served last wins.
module rr_pick2
  import rv32_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       gnt
);

  // Combinational pick; on contention grant the requester other than last.
  always_comb begin
    any = |req;
    gnt = GNT_I;
    case (req)
      2'b01:   gnt = GNT_I;
      2'b10:   gnt = GNT_D;
      2'b11:   gnt = ~last;
      default: gnt = GNT_I;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-cache miss path and the
// D-cache. One transfer at a time, round-robin on contention, with a sticky
// watchdog flag for transfers that never see MBUSYWAIT fall.
//
// state | meaning
// IDLE  | no transfer; arbitrate and latch address/data/op on a grant
// ISSUE | strobe out for the first cycle; MBUSYWAIT not yet meaningful
// WAIT  | strobe held until MBUSYWAIT falls or the watchdog expires
// DONE  | strobes low; owner's BUSYWAIT drops for this one cycle
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREAD,
  input  logic [ADDR_W-1:0] IADDR,
  output logic              IBUSYWAIT,
  output logic [DATA_W-1:0] IREADDATA,
  input  logic              DREAD,
  input  logic              DWRITE,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic [DATA_W-1:0] DWRITEDATA,
  output logic              DBUSYWAIT,
  output logic [DATA_W-1:0] DREADDATA,
  output logic              MREAD,
  output logic              MWRITE,
  output logic [ADDR_W-1:0] MADDR,
  output logic [DATA_W-1:0] MWRITEDATA,
  input  logic [DATA_W-1:0] MREADDATA,
  input  logic              MBUSYWAIT,
  output logic              TIMEOUT_ERR
);

  // Counter holds values 0..TIMEOUT_CYCLES; a zero limit disables the watchdog.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_TERM =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t            state, state_nxt;
  logic              gnt;
  logic              last;
  logic              op;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  cnt;
  logic              req_any;
  logic              pick_gnt;
  logic              d_req;
  logic              wd_fire;

  assign d_req = DREAD | DWRITE;

  rr_pick2 u_pick (
    .req  ({d_req, IREAD}),
    .last (last),
    .any  (req_any),
    .gnt  (pick_gnt)
  );

  // Fires on the WAIT edge that would bring the count up to the limit.
  assign wd_fire = WD_EN && (cnt == CNT_TERM);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; memory completion takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (!MBUSYWAIT || wd_fire) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Grant, address/data/op latches, strobes, read-data capture and error flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      gnt         <= GNT_I;
      last        <= GNT_I;
      op          <= OP_RD;
      MREAD       <= 1'b0;
      MWRITE      <= 1'b0;
      MADDR       <= '0;
      MWRITEDATA  <= '0;
      rdata       <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            gnt <= pick_gnt;
            if (pick_gnt == GNT_D) begin
              MADDR      <= DADDR;
              MWRITEDATA <= DWRITEDATA;
              op         <= DWRITE ? OP_WR : OP_RD;
              MREAD      <= ~DWRITE;
              MWRITE     <= DWRITE;
            end else begin
              MADDR  <= IADDR;
              op     <= OP_RD;
              MREAD  <= 1'b1;
              MWRITE <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!MBUSYWAIT) begin
            if (op == OP_RD) rdata <= MREADDATA;
            MREAD  <= 1'b0;
            MWRITE <= 1'b0;
          end else if (wd_fire) begin
            TIMEOUT_ERR <= 1'b1;
            MREAD       <= 1'b0;
            MWRITE      <= 1'b0;
          end
        end
        ST_DONE: last <= gnt;
        default: ;
      endcase
    end
  end

  // Watchdog: cleared when a transfer is granted, counts WAIT cycles, saturates.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (state == ST_IDLE && req_any) begin
      cnt <= '0;
    end else if (state == ST_WAIT && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign IBUSYWAIT = IREAD & ~(state == ST_DONE && gnt == GNT_I);
  assign DBUSYWAIT = d_req & ~(state == ST_DONE && gnt == GNT_D);
  assign IREADDATA = rdata;
  assign DREADDATA = rdata;

endmodule
